// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants for the fetch stage: instruction width and PC increments.
package instr_prefetch_queue_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned PC_STEP        = 4;
  localparam int unsigned PC_READ_OFFSET = 8;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-stage bus: instruction-memory port, branch redirect and decode handshake.
interface instr_prefetch_queue_if
  import instr_prefetch_queue_pkg::*;
#(
  parameter int W = INSTR_W
);

  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_rd_data;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic         dec_ready;
  logic         dec_valid;
  logic [W-1:0] dec_instr;
  logic [W-1:0] dec_pc_plus8;

  // master is the prefetch queue; slave is memory, execute and decode around it
  modport master (
    output imem_addr,
    input  imem_rd_data,
    input  branch_taken,
    input  branch_target,
    input  dec_ready,
    output dec_valid,
    output dec_instr,
    output dec_pc_plus8
  );

  modport slave (
    input  imem_addr,
    output imem_rd_data,
    output branch_taken,
    output branch_target,
    output dec_ready,
    input  dec_valid,
    input  dec_instr,
    input  dec_pc_plus8
  );

endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// Small circular buffer of fetched {instruction, pc+8} pairs with a synchronous flush.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_MAX) || do_pop);

  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: owns the fetch PC, queues fetched words and hands them to decode one per cycle.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int           W        = INSTR_W,
  parameter int           DEPTH    = 4,
  parameter logic [W-1:0] PC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_prefetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = DEPTH[AW:0];

  logic [W-1:0]   fetch_pc;
  logic           push;
  logic           pop;
  logic           empty;
  logic [AW:0]    count;
  logic [2*W-1:0] head;
  logic [2*W-1:0] wr_data;

  assign bus.imem_addr = fetch_pc;

  // Branch wins over everything; a pop in the same cycle still retires the head
  assign pop     = !empty && bus.dec_ready;
  assign push    = !bus.branch_taken && ((count != CNT_MAX) || pop);
  assign wr_data = {bus.imem_rd_data, fetch_pc + W'(PC_READ_OFFSET)};

  instr_fifo #(
    .DEPTH (DEPTH),
    .DW    (2*W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.branch_taken),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= PC_RESET;
    end else if (bus.branch_taken) begin
      fetch_pc <= bus.branch_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + W'(PC_STEP);
    end
  end

  // Stale storage contents must never leak onto decode while the queue is empty
  assign bus.dec_valid    = !empty;
  assign bus.dec_instr    = empty ? '0 : head[2*W-1:W];
  assign bus.dec_pc_plus8 = empty ? '0 : head[W-1:0];

endmodule
